// File: rtl/mem_rr_arbiter_if.sv
// rtl/mem_rr_arbiter_if.sv - requester and RAM pin bundle for mem_rr_arbiter
interface mem_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_W-1:0]     req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          mem_wea;
  logic                          mem_reb;
  logic [ADDR_W-1:0]             mem_addra;
  logic [ADDR_W-1:0]             mem_addrb;
  logic [DATA_WIDTH-1:0]         mem_dia;
  logic [DATA_WIDTH-1:0]         mem_dob;
  logic                          busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_dob,
    output req_ready, rsp_valid, rsp_data, mem_wea, mem_reb,
           mem_addra, mem_addrb, mem_dia, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_dob,
    input  req_ready, rsp_valid, rsp_data, mem_wea, mem_reb,
           mem_addra, mem_addrb, mem_dia, busy
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing one simple dual-port RAM
module mem_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input logic             clk,
  input logic             reset_n,
  mem_rr_arbiter_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int IDX_W  = $clog2(NUM_REQ);

  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      cand_idx;
  logic                  found;
  logic                  granted;
  logic                  wr_grant;
  logic                  rd_grant;
  logic [NUM_REQ-1:0]    grant_vec;
  logic [NUM_REQ-1:0]    rd_vec;
  logic [ADDR_W-1:0]     win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  int                    cand;

  // Search starts one past the previous winner and wraps around.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && bus.req_valid[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Gating with reset_n keeps ready and the RAM strobes quiet while held in reset.
  always_comb begin
    granted   = found & reset_n;
    grant_vec = granted ? (NUM_REQ'(1) << win_idx) : '0;
    win_addr  = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_wdata = bus.req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    wr_grant  = granted & bus.req_we[win_idx];
    rd_grant  = granted & ~bus.req_we[win_idx];
    rd_vec    = rd_grant ? grant_vec : '0;
  end

  assign bus.req_ready = grant_vec;
  assign bus.mem_wea   = wr_grant;
  assign bus.mem_reb   = rd_grant;
  assign bus.mem_addra = wr_grant ? win_addr : '0;
  assign bus.mem_dia   = wr_grant ? win_wdata : '0;
  assign bus.mem_addrb = rd_grant ? win_addr : '0;
  assign bus.rsp_data  = bus.mem_dob;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (granted) begin
      last_grant <= win_idx;
    end
  end

  // Response tags travel alongside the RAM's own output delay.
  if (READ_LATENCY == 0) begin : g_lat0
    assign bus.rsp_valid = rd_vec;
    assign bus.busy      = 1'b0;
  end else begin : g_pipe
    logic [NUM_REQ-1:0] stage [READ_LATENCY];
    logic [NUM_REQ-1:0] stage_or;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s < READ_LATENCY; s++) begin
          stage[s] <= '0;
        end
      end else begin
        stage[0] <= rd_vec;
        for (int s = 1; s < READ_LATENCY; s++) begin
          stage[s] <= stage[s-1];
        end
      end
    end

    always_comb begin
      stage_or = '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        stage_or = stage_or | stage[s];
      end
    end

    assign bus.rsp_valid = stage[READ_LATENCY-1];
    assign bus.busy      = |stage_or;
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - scoreboard bench for mem_rr_arbiter at read latencies 0, 1 and 2
module tb_mem_rr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;

  logic [N-1:0]  ready_o [3];
  logic [N-1:0]  rsp_o   [3];
  logic [DW-1:0] data_o  [3];
  logic [AW-1:0] addra_o [3];
  logic [AW-1:0] addrb_o [3];
  logic [DW-1:0] dia_o   [3];
  logic          wea_o   [3];
  logic          reb_o   [3];
  logic          busy_o  [3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : lat
    mem_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_W(AW)) bus ();
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;

    assign bus.req_valid = req_valid;
    assign bus.req_we    = req_we;
    assign bus.req_addr  = req_addr;
    assign bus.req_wdata = req_wdata;
    assign bus.mem_dob   = (g == 0) ? ram[bus.mem_addrb] : ((g == 1) ? d1 : d2);

    always @(posedge clk) begin
      if (bus.mem_wea) ram[bus.mem_addra] <= bus.mem_dia;
      if (bus.mem_reb) d1 <= ram[bus.mem_addrb];
      d2 <= d1;
    end

    mem_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(g)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
    );

    assign ready_o[g] = bus.req_ready;
    assign rsp_o[g]   = bus.rsp_valid;
    assign data_o[g]  = bus.rsp_data;
    assign addra_o[g] = bus.mem_addra;
    assign addrb_o[g] = bus.mem_addrb;
    assign dia_o[g]   = bus.mem_dia;
    assign wea_o[g]   = bus.mem_wea;
    assign reb_o[g]   = bus.mem_reb;
    assign busy_o[g]  = bus.busy;
  end

  typedef struct {
    int         inst;
    int         rid;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sbq [$];
  logic [7:0] model [DEPTH];
  int         model_last;
  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;
  logic [2:0] busy_snap;
  logic [2:0] rsp_snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [3:0] v);
    int r;
    r = -1;
    for (int k = 1; k <= N; k++) begin
      if (r < 0 && v[(last + k) % N]) r = (last + k) % N;
    end
    return r;
  endfunction

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int r, input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid[r]       = 1'b1;
    req_we[r]          = we;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  // One cycle: check grant and RAM pins against the model, queue expected read data.
  task automatic run_cycle(input string tag, output logic [3:0] got);
    int         w;
    logic [7:0] a;
    logic [7:0] d;
    @(negedge clk);
    got = ready_o[1];
    for (int g = 0; g < 3; g++) begin
      busy_snap[g] = busy_o[g];
      rsp_snap[g]  = |rsp_o[g];
    end
    w = pick(model_last, reset_n ? req_valid : 4'b0);
    for (int g = 0; g < 3; g++)
      check($sformatf("%s_ready_l%0d", tag, g), ready_o[g], (w < 0) ? 0 : (32'd1 << w));
    if (w >= 0) begin
      a = req_addr[w*AW +: AW];
      d = req_wdata[w*DW +: DW];
      if (req_we[w]) begin
        for (int g = 0; g < 3; g++) begin
          check($sformatf("%s_wea_l%0d", tag, g), wea_o[g], 1);
          check($sformatf("%s_reb_l%0d", tag, g), reb_o[g], 0);
          check($sformatf("%s_addra_l%0d", tag, g), addra_o[g], a);
          check($sformatf("%s_dia_l%0d", tag, g), dia_o[g], d);
        end
        model[a] = d;
      end else begin
        for (int g = 0; g < 3; g++) begin
          check($sformatf("%s_reb_l%0d", tag, g), reb_o[g], 1);
          check($sformatf("%s_wea_l%0d", tag, g), wea_o[g], 0);
          check($sformatf("%s_addrb_l%0d", tag, g), addrb_o[g], a);
          sbq.push_back('{inst: g, rid: w, data: model[a], due: cyc + g});
        end
      end
      model_last = w;
    end else begin
      for (int g = 0; g < 3; g++) begin
        check($sformatf("%s_idle_pins_l%0d", tag, g),
              {wea_o[g], reb_o[g], addra_o[g], addrb_o[g], dia_o[g]}, 0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the oldest expectation per instance.
  int mon_idx;
  always @(negedge clk) begin
    #2;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("excl_l%0d", g), {31'b0, wea_o[g] & reb_o[g]}, 0);
      if (rsp_o[g] != '0) begin
        mon_idx = -1;
        for (int i = 0; i < sbq.size(); i++)
          if (mon_idx < 0 && sbq[i].inst == g) mon_idx = i;
        if (mon_idx < 0) begin
          check($sformatf("unexpected_rsp_l%0d", g), rsp_o[g], 0);
        end else begin
          check($sformatf("rsp_valid_l%0d", g), rsp_o[g], 32'd1 << sbq[mon_idx].rid);
          check($sformatf("rsp_data_l%0d", g), data_o[g], sbq[mon_idx].data);
          check($sformatf("rsp_cycle_l%0d", g), cyc, sbq[mon_idx].due);
          sbq.delete(mon_idx);
        end
      end
    end
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due < cyc) begin
        check($sformatf("missing_rsp_l%0d", sbq[i].inst), cyc, sbq[i].due);
        sbq.delete(i);
      end
    end
  end

  logic [3:0] got;
  logic [3:0] seq [5];

  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    model_last = N - 1;
    reset_n = 1'b0;
    clear_req();
    req_valid = 4'hF;

    // Held in reset with every requester asking.
    for (int k = 0; k < 2; k++) begin
      run_cycle("reset", got);
      for (int g = 0; g < 3; g++) begin
        check($sformatf("reset_busy_l%0d", g), busy_snap[g], 0);
        check($sformatf("reset_rsp_l%0d", g), rsp_snap[g], 0);
      end
    end
    reset_n = 1'b1;
    clear_req();

    // Preload through requester 0.
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 8'h10 + 8'(k), (k == 0) ? 8'h5A : 8'(8'h11 * k));
      run_cycle("preload", got);
      clear_req();
    end
    for (int k = 0; k < 3; k++) run_cycle("drain0", got);

    // Reset pulse, then all four read: strict rotation from requester 0.
    reset_n = 1'b0;
    model_last = N - 1;
    sbq.delete();
    run_cycle("rstpulse", got);
    reset_n = 1'b1;
    for (int r = 0; r < 4; r++) set_req(r, 1'b0, 8'h10 + 8'(r), 8'h00);
    for (int k = 0; k < 5; k++) begin
      run_cycle("rotate", got);
      check($sformatf("rotate_seq%0d", k), got, seq[k]);
    end
    clear_req();
    for (int k = 0; k < 3; k++) run_cycle("drain1", got);

    // Write then immediate read of the same address.
    set_req(2, 1'b1, 8'h3C, 8'hA5);
    run_cycle("wr3c", got);
    clear_req();
    set_req(1, 1'b0, 8'h3C, 8'h00);
    run_cycle("rd3c", got);
    check("rd3c_grant", got, 4'b0010);
    clear_req();
    for (int k = 0; k < 3; k++) run_cycle("drain2", got);

    // Latency sweep: busy for exactly L cycles after the grant.
    set_req(3, 1'b0, 8'h10, 8'h00);
    run_cycle("sweep", got);
    for (int g = 0; g < 3; g++) check($sformatf("sweep_busy0_l%0d", g), busy_snap[g], 0);
    clear_req();
    for (int k = 1; k <= 3; k++) begin
      run_cycle("sweep_tail", got);
      for (int g = 0; g < 3; g++)
        check($sformatf("sweep_busy%0d_l%0d", k, g), busy_snap[g], (k <= g) ? 1 : 0);
    end

    // Fairness with requesters 1 and 2 idle.
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(3, 1'b0, 8'h13, 8'h00);
    for (int k = 0; k < 6; k++) begin
      run_cycle("fair", got);
      check($sformatf("fair_seq%0d", k), got, (k % 2) ? 4'b1000 : 4'b0001);
    end
    clear_req();
    for (int k = 0; k < 3; k++) run_cycle("drain3", got);

    // Reset while a read is in flight: nothing may come back.
    set_req(2, 1'b0, 8'h12, 8'h00);
    run_cycle("flight", got);
    clear_req();
    reset_n = 1'b0;
    model_last = N - 1;
    sbq.delete();
    for (int k = 0; k < 2; k++) begin
      run_cycle("inreset", got);
      for (int g = 0; g < 3; g++) check($sformatf("inreset_busy_l%0d", g), busy_snap[g], 0);
    end
    reset_n = 1'b1;
    for (int r = 0; r < 4; r++) set_req(r, 1'b0, 8'h10 + 8'(r), 8'h00);
    run_cycle("postreset", got);
    check("postreset_first", got, 4'b0001);
    clear_req();
    for (int k = 0; k < 3; k++) run_cycle("drain4", got);

    // Long idle, then confirm RAM contents survived.
    for (int k = 0; k < 10; k++) begin
      run_cycle("idle", got);
      check($sformatf("idle_rsp%0d", k), {29'b0, rsp_snap}, 0);
    end
    set_req(1, 1'b0, 8'h3C, 8'h00);
    run_cycle("hold3c", got);
    clear_req();
    set_req(0, 1'b0, 8'h10, 8'h00);
    run_cycle("hold10", got);
    clear_req();
    for (int k = 0; k < 4; k++) run_cycle("drain5", got);
    check("scoreboard_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin access controller that shares one `mem_simple_dual_port` instance between `NUM_REQ` requesters in the OPL3 core, e.g. the host register-write path, the operator sequencer and the debug readback port. It accepts at most one transaction per clock, either a write to port A or a read from port B. It drives the RAM's `wea`/`reb`/address/data pins and returns read data to the issuing requester after the RAM's configured output delay, tagged with a one-hot response valid.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: RAM word width. Must equal the RAM's `DATA_WIDTH`.
- `DEPTH`, 256: RAM depth. `ADDR_W = $clog2(DEPTH)`.
- `READ_LATENCY`, 1: must equal the RAM's `OUTPUT_DELAY`. Legal values are 0, 1, 2.

Ports:
- `clk`, in, 1: single clock for the block and the RAM (`clka` = `clkb` = `clk`).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NUM_REQ`: per-requester request present.
- `req_we`, in, `NUM_REQ`: 1 = write, 0 = read.
- `req_addr`, in, `NUM_REQ*ADDR_W`: packed addresses. Requester i occupies slice `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`, in, `NUM_REQ*DATA_WIDTH`: packed write data, packed the same way.
- `req_ready`, out, `NUM_REQ`: one-hot grant. A transaction completes when `req_valid[i] & req_ready[i]`.
- `rsp_valid`, out, `NUM_REQ`: one-hot pulse marking read data for requester i.
- `rsp_data`, out, `DATA_WIDTH`: shared read data. Meaningful only while `rsp_valid != 0`.
- `mem_wea`, `mem_reb`, out, 1: RAM write enable and read enable.
- `mem_addra`, `mem_addrb`, out, `ADDR_W`: RAM write address and read address.
- `mem_dia`, out, `DATA_WIDTH`: RAM write data.
- `mem_dob`, in, `DATA_WIDTH`: RAM read data.
- `busy`, out, 1: high while any read is in flight (pipeline not empty).

## Operation
- Arbitration:
  - Round-robin over `req_valid`.
  - The search starts at `(last_grant+1) mod NUM_REQ` and wraps.
  - `last_grant` is a register, reset to `NUM_REQ-1` so requester 0 wins first after reset.
  - `last_grant` updates only on a cycle with a grant.
- `req_ready`:
  - Combinational one-hot of the winner.
  - All zero when no request is pending or `reset_n` = 0.
  - It does not depend on `req_we`.
- Write grant: `mem_wea`=1, `mem_addra`/`mem_dia` = winner's address/data, `mem_reb`=0.
- Read grant: `mem_reb`=1, `mem_addrb` = winner's address, `mem_wea`=0.
- No grant: `mem_wea`=`mem_reb`=0. The address and data outputs are don't-care but must not be X (drive zero).
- `mem_wea` and `mem_reb` are never high in the same cycle.
- Response pipeline:
  - A `READ_LATENCY`-deep shift register of the one-hot read-grant vector.
  - `rsp_valid` is its last stage. For `READ_LATENCY`=0, `rsp_valid` = read grant combinationally.
  - `rsp_data` = `mem_dob`, passed through with no extra register.
- `busy` = OR of all pipeline stages. It is always 0 when `READ_LATENCY`=0.
- Requesters must hold `req_valid`, `req_we`, `req_addr`, `req_wdata` stable until their ready. The arbiter does not buffer requests.
- Ordering: one grant per cycle makes every access serialized. A read granted the cycle after a write to the same address returns the new data.
- Fairness: with all requesters continuously valid, each is granted exactly once every `NUM_REQ` cycles.

## Timing
- Reset (`reset_n` low, async):
  - `last_grant` = `NUM_REQ-1`.
  - Pipeline cleared.
  - `rsp_valid`=0, `busy`=0, `req_ready`=0, `mem_wea`=`mem_reb`=0.
- Reset mid-operation: in-flight reads are discarded, so no `rsp_valid` pulse is produced for them. The first grant after release goes to requester 0.
- Write: granted in cycle T. The RAM is updated at the clock edge ending T.
- Read with `READ_LATENCY`=L, granted in cycle T: `rsp_valid[i]`=1 and `rsp_data` valid in cycle T+L, for exactly one cycle.
- Back-to-back reads from different requesters produce consecutive `rsp_valid` pulses in grant order, one per cycle.
- Throughput: one access per cycle, sustained.

## Test plan
- **Reset and first grant:** `NUM_REQ`=4, L=1. Pulse `reset_n` low, then raise all four `req_valid` (reads) -> `req_ready` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- **Write then read:**
  - Stimulus: requester 2 writes 0xA5 to address 0x3C in cycle T; requester 1 reads 0x3C in T+1.
  - Required: `rsp_valid`=0010 and `rsp_data`=0xA5 in T+2. `mem_wea` and `mem_reb` are never both 1.
- **Latency sweep:** for L=0, 1, 2, requester 3 reads preloaded address 0x10 (value 0x5A) -> `rsp_valid`=1000 exactly L cycles after the grant, with `rsp_data`=0x5A. `busy` is high for L cycles.
- **Fairness under skip:** requesters 0 and 3 are always valid, 1 and 2 idle -> grants alternate 0, 3, 0, 3. `last_grant` wraps 3 -> 0 correctly.
- **Reset mid-flight:**
  - Stimulus: L=2, read granted in T, `reset_n` asserted low in T+1, released in T+3.
  - Required: no `rsp_valid` pulse at any time and `busy`=0 from reset assertion. The next grant goes to requester 0.
- **Idle and hold:** no `req_valid` for 10 cycles -> `req_ready`=0, `mem_wea`=`mem_reb`=0, `rsp_valid`=0, and the RAM contents are unchanged.
